// File: rtl/rtc_dir_scan.sv
// Sweeps the RTC register file: latch write to F0h, ten reads, then an atomic
// commit of all captured bytes to the outputs. A per-cycle ack timeout aborts the sweep.
module rtc_dir_scan #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       req,
    output logic       we,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic       ack,
    input  logic [7:0] rdata,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] seg_t,
    output logic [7:0] min_t,
    output logic [7:0] hora_t,
    output logic [7:0] stat,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LATCH, GAP, READ, COMMIT, ERROR} state_t;

    state_t     state, next;
    logic [3:0] idx;
    logic [7:0] timer;
    logic [7:0] rd_addr;
    logic [7:0] shadow [10];
    logic [7:0] outs   [10];
    logic       timeout;

    always_comb begin
        case (idx)
            4'd7:    rd_addr = 8'h41;
            4'd8:    rd_addr = 8'h42;
            4'd9:    rd_addr = 8'h43;
            default: rd_addr = 8'h20 + {4'h0, idx};
        endcase
    end

    // ack beats the timer when both land in the same cycle
    assign timeout = req && !ack && (timer == TIMEOUT);

    always_comb begin
        next  = state;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        case (state)
            IDLE:   if (start) next = LATCH;
            LATCH: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = 8'hF0;
                wdata = 8'hF0;
                if (ack)               next = GAP;
                else if (timer == TIMEOUT) next = ERROR;
            end
            GAP:    next = READ;
            READ: begin
                req  = 1'b1;
                addr = rd_addr;
                if (ack)               next = (idx == 4'd9) ? COMMIT : GAP;
                else if (timer == TIMEOUT) next = ERROR;
            end
            COMMIT: next = IDLE;
            ERROR:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == COMMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= 4'd0;
            timer <= 8'd0;
            err   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                shadow[i] <= 8'h00;
                outs[i]   <= 8'h00;
            end
        end else begin
            state <= next;
            if (state == IDLE || state == GAP)
                timer <= 8'd0;
            else if (req && !ack && !timeout)
                timer <= timer + 8'd1;
            if (state == IDLE && start) begin
                idx <= 4'd0;
                err <= 1'b0;
            end
            if (timeout)
                err <= 1'b1;
            if (state == READ && ack) begin
                shadow[idx] <= rdata;
                if (idx != 4'd9) idx <= idx + 4'd1;
            end
            // Copy lands on entry to COMMIT so done and the new values share a cycle;
            // the last byte is taken straight from the bus.
            if (state == READ && ack && idx == 4'd9) begin
                for (int i = 0; i < 9; i++) outs[i] <= shadow[i];
                outs[9] <= rdata;
            end
        end
    end

    assign seg    = outs[0];
    assign min    = outs[1];
    assign hora   = outs[2];
    assign dia    = outs[3];
    assign mes    = outs[4];
    assign anio   = outs[5];
    assign seg_t  = outs[6];
    assign min_t  = outs[7];
    assign hora_t = outs[8];
    assign stat   = outs[9];
endmodule
